// File: rtl/ysyx_22040088_trapctrl.sv
// Trap/interrupt sequencer sitting beside the ID stage: drains EX/MEM, saves
// mepc/mcause, then redirects fetch; also handles mret, taken branches and ebreak halt.
module ysyx_22040088_trapctrl #(
    parameter int unsigned DRAIN_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_stall,
    input  logic [63:0] id_pc,
    input  logic        ecall,
    input  logic        mret,
    input  logic        ebreak,
    input  logic        tint,
    input  logic        mie,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    input  logic        mem_busy,
    input  logic [63:0] csr_mtvec,
    input  logic [63:0] csr_mepc,
    output logic        hold_if,
    output logic        hold_id,
    output logic        flush_if,
    output logic        flush_id,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        csr_save,
    output logic [63:0] save_epc,
    output logic [63:0] save_cause,
    output logic        trap_active,
    output logic        halt,
    output logic [31:0] trap_cnt
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DRAIN    = 3'd1,
        S_SAVE     = 3'd2,
        S_REDIRECT = 3'd3,
        S_HALT     = 3'd4
    } state_t;

    localparam logic [63:0] CAUSE_ECALL = 64'd11;
    localparam logic [63:0] CAUSE_TINT  = 64'h8000_0000_0000_0007;
    localparam logic [31:0] DRAIN_LOAD  = (DRAIN_CYC > 32'd0) ? (DRAIN_CYC - 32'd1) : 32'd0;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_drain_cnt;
    logic [63:0] r_epc;
    logic [63:0] r_cause;
    logic [63:0] r_target;
    logic [31:0] r_trap_cnt;

    // Events are only considered on an accepted ID instruction outside reset;
    // the chain below encodes ebreak > ecall > interrupt > mret > branch.
    logic w_ev_ok;
    logic w_int;
    logic w_take_ebreak;
    logic w_take_ecall;
    logic w_take_tint;
    logic w_take_mret;
    logic w_take_br;

    assign w_ev_ok       = id_valid & ~id_stall & rst;
    assign w_int         = tint & mie;
    assign w_take_ebreak = w_ev_ok & ebreak;
    assign w_take_ecall  = w_ev_ok & ~ebreak & ecall;
    assign w_take_tint   = w_ev_ok & ~ebreak & ~ecall & w_int;
    assign w_take_mret   = w_ev_ok & ~ebreak & ~ecall & ~w_int & mret;
    assign w_take_br     = w_ev_ok & ~ebreak & ~ecall & ~w_int & ~mret & br_taken;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_take_ebreak) begin
                    w_next = S_HALT;
                end else if (w_take_ecall | w_take_tint) begin
                    w_next = S_DRAIN;
                end else if (w_take_mret) begin
                    w_next = S_REDIRECT;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                if ((r_drain_cnt == 32'd0) && !mem_busy) begin
                    w_next = S_SAVE;
                end else begin
                    w_next = S_DRAIN;
                end
            end
            S_SAVE:     w_next = S_REDIRECT;
            S_REDIRECT: w_next = S_IDLE;
            S_HALT:     w_next = S_HALT;
            default:    w_next = S_IDLE;
        endcase
    end

    // Control outputs decoded from state (and same-cycle ID events in IDLE)
    always_comb begin
        hold_if        = 1'b0;
        hold_id        = 1'b0;
        flush_if       = 1'b0;
        flush_id       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        csr_save       = 1'b0;
        trap_active    = 1'b1;
        halt           = 1'b0;
        case (r_state)
            S_IDLE: begin
                trap_active = 1'b0;
                if (w_take_ebreak | w_take_ecall | w_take_tint) begin
                    hold_if = 1'b1;
                    hold_id = 1'b1;
                end else if (w_take_br) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = br_target;
                    flush_if       = 1'b1;
                end else begin
                    redirect_pc = 64'd0;
                end
            end
            S_DRAIN: begin
                hold_if = 1'b1;
                hold_id = 1'b1;
            end
            S_SAVE: begin
                hold_if  = 1'b1;
                hold_id  = 1'b1;
                csr_save = 1'b1;
            end
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = r_target;
                flush_if       = 1'b1;
                flush_id       = 1'b1;
            end
            S_HALT: begin
                hold_if = 1'b1;
                hold_id = 1'b1;
                halt    = 1'b1;
            end
            default: begin
                trap_active = 1'b0;
            end
        endcase
    end

    // Trap context latches, drain counter and saturating trap counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_drain_cnt <= 32'd0;
            r_epc       <= 64'd0;
            r_cause     <= 64'd0;
            r_target    <= 64'd0;
            r_trap_cnt  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take_ecall) begin
                        r_epc       <= id_pc;
                        r_cause     <= CAUSE_ECALL;
                        r_drain_cnt <= DRAIN_LOAD;
                    end else if (w_take_tint) begin
                        r_epc       <= id_pc;
                        r_cause     <= CAUSE_TINT;
                        r_drain_cnt <= DRAIN_LOAD;
                    end else if (w_take_mret) begin
                        r_target <= csr_mepc;
                    end else begin
                        r_drain_cnt <= r_drain_cnt;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt != 32'd0) begin
                        r_drain_cnt <= r_drain_cnt - 32'd1;
                    end else begin
                        r_drain_cnt <= 32'd0;
                    end
                end
                S_SAVE: begin
                    r_target <= csr_mtvec;
                    if (r_trap_cnt != 32'hFFFF_FFFF) begin
                        r_trap_cnt <= r_trap_cnt + 32'd1;
                    end else begin
                        r_trap_cnt <= r_trap_cnt;
                    end
                end
                default: begin
                    r_drain_cnt <= r_drain_cnt;
                end
            endcase
        end
    end

    assign save_epc   = r_epc;
    assign save_cause = r_cause;
    assign trap_cnt   = r_trap_cnt;

endmodule
